// File: rtl/node_window_feeder.sv
// node_window_feeder: serial-to-parallel sliding-window writer for the node tap bus.
//   Samples arrive over s_data/s_valid/s_ready and shift into an N_TAPS-deep window.
//   A full window is presented on win_x with win_valid and held until win_ack.
//   After the ack, STRIDE new samples complete the next window.
//   Optional macro FEEDER_WINCNT_EN adds win_cnt, a 16-bit count of accepted acks.
// Ports:
//   clk, reset (async active-low)
//   s_data/s_valid/s_ready  serial sample input handshake
//   flush                   synchronous clear of the window and fill state
//   win_x/win_valid/win_ack parallel window output; tap 0 is the oldest sample
//   fill_cnt                number of samples currently held
//   win_cnt                 accepted-ack counter (FEEDER_WINCNT_EN only)
module node_window_feeder #(
    parameter int N_TAPS = 15,
    parameter int DW     = 16,
    parameter int STRIDE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DW-1:0]      s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               flush,
    output logic [N_TAPS*DW-1:0] win_x,
    output logic               win_valid,
    input  logic               win_ack,
`ifdef FEEDER_WINCNT_EN
    output logic [15:0]        win_cnt,
`endif
    output logic [5:0]         fill_cnt
);
    typedef enum logic {FILL, PRESENT} state_t;
    localparam logic [5:0] N6 = 6'(N_TAPS);
    localparam logic [5:0] S6 = 6'(STRIDE);
    state_t              state_q, state_d;
    logic [N_TAPS*DW-1:0] win_q, win_d;
    logic [5:0]          fill_q, fill_d;
    logic                rdy_q, rdy_d;
    logic                xfer, ack;
    assign xfer      = s_valid & rdy_q & (state_q == FILL);
    assign ack       = win_ack & (state_q == PRESENT) & ~flush;
    assign s_ready   = rdy_q;
    assign win_x     = win_q;
    assign win_valid = (state_q == PRESENT);
    assign fill_cnt  = fill_q;
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        rdy_d   = rdy_q;
        if (flush) begin
            state_d = FILL;
            win_d   = '0;
            fill_d  = '0;
            rdy_d   = 1'b1;
        end else if (state_q == FILL) begin
            rdy_d = 1'b1;
            if (xfer) begin
                // newest sample enters the top tap, everything moves toward tap 0
                win_d  = {s_data, win_q[N_TAPS*DW-1:DW]};
                fill_d = fill_q + 6'd1;
                if (fill_q + 6'd1 == N6) begin
                    state_d = PRESENT;
                    rdy_d   = 1'b0;
                end
            end
        end else if (ack) begin
            // older taps stay in place; only STRIDE fresh samples are needed
            state_d = FILL;
            fill_d  = N6 - S6;
            rdy_d   = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            win_q   <= '0;
            fill_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            rdy_q   <= rdy_d;
        end
    end
`ifdef FEEDER_WINCNT_EN
    logic [15:0] cnt_q;
    assign win_cnt = cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (ack) cnt_q <= cnt_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_node_window_feeder.sv
// tb_node_window_feeder: directed self-checking bench for node_window_feeder.
module tb_node_window_feeder;
    localparam int N  = 15;
    localparam int DW = 16;
    logic          clk = 0;
    logic          reset = 0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 0, flush = 0, win_ack = 0;
    logic          s_valid1 = 0, win_ack1 = 0;
    logic          s_ready, win_valid, s_ready1, win_valid1;
    logic [N*DW-1:0] win_x, win_x1;
    logic [5:0]    fill_cnt, fill_cnt1;
`ifdef FEEDER_WINCNT_EN
    logic [15:0]   win_cnt, win_cnt1;
`endif
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    node_window_feeder #(.N_TAPS(N), .DW(DW), .STRIDE(1)) u0 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .win_x(win_x), .win_valid(win_valid), .win_ack(win_ack),
`ifdef FEEDER_WINCNT_EN
        .win_cnt(win_cnt),
`endif
        .fill_cnt(fill_cnt));
    node_window_feeder #(.N_TAPS(N), .DW(DW), .STRIDE(N)) u1 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid1), .s_ready(s_ready1),
        .flush(flush), .win_x(win_x1), .win_valid(win_valid1), .win_ack(win_ack1),
`ifdef FEEDER_WINCNT_EN
        .win_cnt(win_cnt1),
`endif
        .fill_cnt(fill_cnt1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (win_x !== '0 || win_valid !== 1'b0 || s_ready !== 1'b0 || fill_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: win_valid=%b s_ready=%b fill=%0d want 0 0 0", win_valid, s_ready, fill_cnt);
        end
        tick();
        tick();
        reset = 1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 0", s_ready);
        end
        tick();
        n_checks++;
        if (s_ready !== 1'b1 || fill_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL ready_after_release: s_ready=%b fill=%0d want 1 0", s_ready, fill_cnt);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= N; i++) begin
            s_data = DW'(i);
            s_valid = 1;
            tick();
            n_checks++;
            if (fill_cnt !== 6'(i) || win_valid !== (i == N)) begin
                n_fail++;
                $display("FAIL fill_%0d: fill=%0d win_valid=%b want %0d %b", i, fill_cnt, win_valid, i, i == N);
            end
        end
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ready: got %b want 0", s_ready);
        end
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (win_x[k*DW +: DW] !== DW'(k + 1)) begin
                n_fail++;
                $display("FAIL fill_tap%0d: got %0d want %0d", k, win_x[k*DW +: DW], k + 1);
            end
        end
    endtask

    task automatic test_hold();
        s_data = 16'd99;
        s_valid = 1;
        win_ack = 0;
        for (int c = 0; c < 10; c++) tick();
        n_checks++;
        if (fill_cnt !== 6'd15 || win_valid !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_state: fill=%0d win_valid=%b s_ready=%b want 15 1 0", fill_cnt, win_valid, s_ready);
        end
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (win_x[k*DW +: DW] !== DW'(k + 1)) begin
                n_fail++;
                $display("FAIL hold_tap%0d: got %0d want %0d", k, win_x[k*DW +: DW], k + 1);
            end
        end
    endtask

    task automatic test_advance();
        s_valid = 0;
        win_ack = 1;
        tick();
        n_checks++;
        if (win_valid !== 1'b0 || fill_cnt !== 6'd14 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ack: win_valid=%b fill=%0d s_ready=%b want 0 14 1", win_valid, fill_cnt, s_ready);
        end
`ifdef FEEDER_WINCNT_EN
        n_checks++;
        if (win_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL win_cnt: got %0d want 1", win_cnt);
        end
`endif
        tick();
        win_ack = 0;
        n_checks++;
        if (win_valid !== 1'b0 || fill_cnt !== 6'd14) begin
            n_fail++;
            $display("FAIL stray_ack: win_valid=%b fill=%0d want 0 14", win_valid, fill_cnt);
        end
        s_data = 16'd16;
        s_valid = 1;
        tick();
        s_valid = 0;
        n_checks++;
        if (win_valid !== 1'b1 || fill_cnt !== 6'd15) begin
            n_fail++;
            $display("FAIL advance_valid: win_valid=%b fill=%0d want 1 15", win_valid, fill_cnt);
        end
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (win_x[k*DW +: DW] !== DW'(k + 2)) begin
                n_fail++;
                $display("FAIL advance_tap%0d: got %0d want %0d", k, win_x[k*DW +: DW], k + 2);
            end
        end
    endtask

    task automatic test_flush();
        flush = 1;
        win_ack = 1;
        tick();
        flush = 0;
        win_ack = 0;
        n_checks++;
        if (fill_cnt !== 6'd0 || win_valid !== 1'b0 || win_x !== '0) begin
            n_fail++;
            $display("FAIL flush_over_ack: fill=%0d win_valid=%b want 0 0", fill_cnt, win_valid);
        end
        for (int i = 1; i <= 7; i++) begin
            s_data = DW'(100 + i);
            s_valid = 1;
            tick();
        end
        n_checks++;
        if (fill_cnt !== 6'd7) begin
            n_fail++;
            $display("FAIL partial_fill: got %0d want 7", fill_cnt);
        end
        s_data = 16'd200;
        flush = 1;
        tick();
        flush = 0;
        n_checks++;
        if (fill_cnt !== 6'd0 || win_x !== '0 || win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_over_xfer: fill=%0d win_valid=%b want 0 0", fill_cnt, win_valid);
        end
        for (int i = 1; i <= N; i++) begin
            s_data = DW'(300 + i);
            tick();
            n_checks++;
            if (win_valid !== (i == N)) begin
                n_fail++;
                $display("FAIL refill_%0d: win_valid=%b want %b", i, win_valid, i == N);
            end
        end
        s_valid = 0;
        n_checks++;
        if (win_x[0 +: DW] !== 16'd301 || win_x[(N-1)*DW +: DW] !== 16'd315) begin
            n_fail++;
            $display("FAIL refill_taps: tap0=%0d tap14=%0d want 301 315", win_x[0 +: DW], win_x[(N-1)*DW +: DW]);
        end
    endtask

    task automatic test_stride();
        for (int w = 0; w < 2; w++) begin
            for (int i = 1; i <= N; i++) begin
                s_data = DW'(w * N + i);
                s_valid1 = 1;
                tick();
            end
            s_valid1 = 0;
            n_checks++;
            if (win_valid1 !== 1'b1 || s_ready1 !== 1'b0) begin
                n_fail++;
                $display("FAIL stride_valid%0d: win_valid=%b s_ready=%b want 1 0", w, win_valid1, s_ready1);
            end
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (win_x1[k*DW +: DW] !== DW'(w * N + k + 1)) begin
                    n_fail++;
                    $display("FAIL stride_w%0d_tap%0d: got %0d want %0d", w, k, win_x1[k*DW +: DW], w * N + k + 1);
                end
            end
            win_ack1 = 1;
            tick();
            win_ack1 = 0;
            n_checks++;
            if (fill_cnt1 !== 6'd0 || win_valid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL stride_ack%0d: fill=%0d win_valid=%b want 0 0", w, fill_cnt1, win_valid1);
            end
        end
    endtask

    task automatic test_reset_mid();
        n_checks++;
        if (win_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b want 1", win_valid);
        end
        #2;
        reset = 0;
        #1;
        n_checks++;
        if (win_x !== '0 || win_valid !== 1'b0 || s_ready !== 1'b0 || fill_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_reset: win_valid=%b s_ready=%b fill=%0d want 0 0 0", win_valid, s_ready, fill_cnt);
        end
        tick();
        reset = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold();
        test_advance();
        test_flush();
        test_stride();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
